lms_sign_update: RTL and testbench



---
 rtl/lms_pkg.sv | 25 ++
 rtl/lms_tap_alu.sv | 38 +++
 rtl/lms_sign_update.sv | 157 +++++++++++++++
 tb/tb_lms_sign_update.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared definitions for the sign-sign LMS update engine and the 2-bit FIR tap bank.
package lms_pkg;

    localparam int unsigned CODE_SIGN_BIT = 0;
    localparam int unsigned CODE_MAG_BIT  = 1;

    typedef logic [1:0] tap_code_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } lms_state_t;

    // Map a signed accumulator value to the 2-bit {large, negative} tap code.
    function automatic tap_code_t quantize(input logic signed [31:0] acc, input int thresh);
        logic signed [31:0] mag;
        tap_code_t          q;
        mag = (acc < 0) ? -acc : acc;
        q = '0;
        q[CODE_MAG_BIT]  = (mag >= thresh);
        q[CODE_SIGN_BIT] = (acc < 0);
        return q;
    endfunction

endpackage

// File: rtl/lms_tap_alu.sv
// Per-tap combinational update: optional leak, +/-STEP with saturation, re-quantization.
module lms_tap_alu
    import lms_pkg::*;
#(
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned STEP   = 1,
    parameter int unsigned THRESH = 256
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    dir,
    input  logic signed [ACC_W-1:0] leak,
    output logic signed [ACC_W-1:0] acc_new,
    output tap_code_t               code
);

    localparam int unsigned EW = ACC_W + 2;
    localparam logic signed [EW-1:0] ACC_MAX = EW'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [EW-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [EW-1:0] STEP_E  = EW'(STEP);

    logic signed [EW-1:0] base;
    logic signed [EW-1:0] sum;

    // Two guard bits keep the intermediate sum exact before clamping.
    always_comb begin
        base = EW'(acc) - EW'(leak);
        sum  = dir ? (base - STEP_E) : (base + STEP_E);
        if (sum > ACC_MAX) begin
            acc_new = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            acc_new = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_new = sum[ACC_W-1:0];
        end
        code = quantize(32'(acc_new), int'(THRESH));
    end

endmodule

// File: rtl/lms_sign_update.sv
// Sign-sign LMS weight-update engine feeding the 2-bit FIR tap bank's update port.
// Optional leakage enabled by defining LMS_LEAKAGE_EN.
module lms_sign_update
    import lms_pkg::*;
#(
    parameter int unsigned N          = 1008,
    parameter int unsigned ERR_W      = 24,
    parameter int unsigned ACC_W      = 12,
    parameter int unsigned STEP       = 1,
    parameter int unsigned THRESH     = 256,
    parameter int unsigned LEAK_SHIFT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_data_in,
    input  logic [1:0]           data_in,
    input  logic                 valid_err_in,
    input  logic [ERR_W-1:0]     err_in,
    output logic                 valid_update_out,
    output logic [$clog2(N)-1:0] update_idx,
    output logic [1:0]           update_data,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
`ifdef LMS_LEAKAGE_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    lms_state_t state;
    lms_state_t state_next;
    logic       start_sweep_c;
    logic       sweep_last_c;

    logic [IDX_W-1:0]        tap_idx;
    logic                    sgn_e;
    tap_code_t               hist   [N];
    tap_code_t               shadow [N];
    logic signed [ACC_W-1:0] acc    [N];
    logic                    pend_valid;
    tap_code_t               pend_data;

    logic signed [ACC_W-1:0] cur_acc;
    logic signed [ACC_W-1:0] leak_c;
    logic                    dir_c;
    logic signed [ACC_W-1:0] acc_new;
    tap_code_t               code_new;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        start_sweep_c = 1'b0;
        sweep_last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_err_in && (err_in != '0)) begin
                    state_next    = SWEEP;
                    start_sweep_c = 1'b1;
                end
            end
            SWEEP: begin
                if (tap_idx == LAST_IDX) begin
                    state_next   = IDLE;
                    sweep_last_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cur_acc = acc[tap_idx];
    assign leak_c  = LEAK_EN ? (cur_acc >>> LEAK_SHIFT) : '0;
    assign dir_c   = sgn_e ^ hist[tap_idx][CODE_SIGN_BIT];

    lms_tap_alu #(
        .ACC_W  (ACC_W),
        .STEP   (STEP),
        .THRESH (THRESH)
    ) u_alu (
        .acc     (cur_acc),
        .dir     (dir_c),
        .leak    (leak_c),
        .acc_new (acc_new),
        .code    (code_new)
    );

    // History, accumulators, shadow codes and the registered update port.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                acc[k]    <= '0;
                shadow[k] <= '0;
                hist[k]   <= '0;
            end
            tap_idx          <= '0;
            sgn_e            <= 1'b0;
            pend_valid       <= 1'b0;
            pend_data        <= '0;
            valid_update_out <= 1'b0;
            update_idx       <= '0;
            update_data      <= '0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            valid_update_out <= 1'b0;
            busy             <= (state_next == SWEEP);
            if (state == IDLE) begin
                // A held sample is older than a fresh one, so it lands one slot deeper.
                if (pend_valid && valid_data_in) begin
                    hist[0] <= data_in;
                    hist[1] <= pend_data;
                    for (int k = 2; k < N; k++) hist[k] <= hist[k-2];
                end else if (pend_valid || valid_data_in) begin
                    hist[0] <= pend_valid ? pend_data : data_in;
                    for (int k = 1; k < N; k++) hist[k] <= hist[k-1];
                end
                pend_valid <= 1'b0;
                if (start_sweep_c) begin
                    sgn_e   <= err_in[ERR_W-1];
                    tap_idx <= '0;
                end
            end else begin
                acc[tap_idx] <= acc_new;
                if (code_new != shadow[tap_idx]) begin
                    shadow[tap_idx]  <= code_new;
                    valid_update_out <= 1'b1;
                    update_idx       <= tap_idx;
                    update_data      <= code_new;
                end
                tap_idx <= sweep_last_c ? '0 : (tap_idx + IDX_W'(1));
                if (valid_data_in) begin
                    if (pend_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_data  <= data_in;
                    end
                end
                if (valid_err_in) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lms_sign_update.sv
// Scoreboard bench for lms_sign_update on a reduced configuration (16 taps, 6-bit accumulators).
module tb_lms_sign_update;

    localparam int N          = 16;
    localparam int ERR_W      = 24;
    localparam int ACC_W      = 6;
    localparam int STEP       = 1;
    localparam int THRESH     = 2;
    localparam int LEAK_SHIFT = 8;
    localparam int IDX_W      = $clog2(N);
    localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN    = -(1 << (ACC_W - 1));

    logic             clock;
    logic             reset;
    logic             valid_data_in;
    logic [1:0]       data_in;
    logic             valid_err_in;
    logic [ERR_W-1:0] err_in;
    logic             valid_update_out;
    logic [IDX_W-1:0] update_idx;
    logic [1:0]       update_data;
    logic             busy;
    logic             overrun;

    lms_sign_update #(
        .N          (N),
        .ERR_W      (ERR_W),
        .ACC_W      (ACC_W),
        .STEP       (STEP),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .valid_data_in    (valid_data_in),
        .data_in          (data_in),
        .valid_err_in     (valid_err_in),
        .err_in           (err_in),
        .valid_update_out (valid_update_out),
        .update_idx       (update_idx),
        .update_data      (update_data),
        .busy             (busy),
        .overrun          (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int code;
    } upd_t;

    upd_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: tap values as plain integers, history as newest-first array.
    int macc [N];
    int msh  [N];
    int mh   [N];
    bit m_overrun;

    function automatic void m_reset();
        for (int t = 0; t < N; t++) begin
            macc[t] = 0;
            msh[t]  = 0;
            mh[t]   = 0;
        end
        m_overrun = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void m_shift(input int code);
        for (int t = N - 1; t > 0; t--) mh[t] = mh[t-1];
        mh[0] = code;
    endfunction

    function automatic void m_sweep(input bit neg);
        for (int t = 0; t < N; t++) begin
            int a;
            int q;
            int mag;
            bit dir;
            a = macc[t];
`ifdef LMS_LEAKAGE_EN
            a = a - (a >>> LEAK_SHIFT);
`endif
            dir = neg ^ bit'(mh[t] & 1);
            a = dir ? (a - STEP) : (a + STEP);
            if (a > ACC_MAX) a = ACC_MAX;
            if (a < ACC_MIN) a = ACC_MIN;
            mag = (a < 0) ? -a : a;
            q = ((mag >= THRESH) ? 2 : 0) + ((a < 0) ? 1 : 0);
            if (q != msh[t]) begin
                exp_q.push_back('{t, q});
                msh[t] = q;
            end
            macc[t] = a;
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every presented update must be the next expected one.
    initial begin
        upd_t e;
        forever begin
            @(negedge clock);
            if (valid_update_out === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_update: got idx=%0d data=%0d, expected none", update_idx, update_data);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(update_idx) != e.idx || int'(update_data) != e.code) begin
                        miscompares++;
                        $display("FAIL update: got idx=%0d data=%0d, expected idx=%0d data=%0d",
                                 update_idx, update_data, e.idx, e.code);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset         = 1'b1;
        valid_data_in = 1'b0;
        valid_err_in  = 1'b0;
        data_in       = '0;
        err_in        = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_reset();
    endtask

    // One IDLE-cycle transaction, optionally followed by a sweep with in-sweep stimulus.
    task automatic issue(input bit d, input logic [1:0] code, input bit ev, input int e,
                         input int n_mid, input bit mid_err);
        int         cnt;
        bit         exp_sweep;
        bit         pend_set;
        logic [1:0] pend_code;
        logic [1:0] mc;
        exp_sweep     = ev && (e != 0);
        valid_data_in = d;
        data_in       = code;
        valid_err_in  = ev;
        err_in        = ERR_W'(e);
        if (d) m_shift(int'(code));
        if (exp_sweep) m_sweep(e < 0);
        @(negedge clock);
        valid_data_in = 1'b0;
        valid_err_in  = 1'b0;
        cnt      = 0;
        pend_set = 1'b0;
        pend_code = '0;
        for (int c = 0; c < N + 8; c++) begin
            if (busy !== 1'b1) break;
            cnt++;
            valid_data_in = 1'b0;
            valid_err_in  = 1'b0;
            if ((cnt == 3 && n_mid >= 1) || (cnt == 5 && n_mid >= 2)) begin
                mc = 2'($urandom);
                valid_data_in = 1'b1;
                data_in       = mc;
                if (!pend_set) begin
                    pend_set  = 1'b1;
                    pend_code = mc;
                end else begin
                    m_overrun = 1'b1;
                end
            end
            if (cnt == 7 && mid_err) begin
                valid_err_in = 1'b1;
                err_in       = ERR_W'($urandom_range(1, 100));
                m_overrun    = 1'b1;
            end
            @(negedge clock);
        end
        valid_data_in = 1'b0;
        valid_err_in  = 1'b0;
        check("busy_cycles", cnt, exp_sweep ? N : 0);
        if (pend_set) m_shift(int'(pend_code));
        check("overrun", int'(overrun), int'(m_overrun));
    endtask

    task automatic fill(input logic [1:0] code);
        for (int k = 0; k < N; k++) issue(1'b1, code, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int         r;
        int         e;
        bit         d;
        bit         ev;
        logic [1:0] code;

        do_reset();
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid_update_out), 0);
        check("reset_idx", int'(update_idx), 0);
        check("reset_data", int'(update_data), 0);
        check("reset_overrun", int'(overrun), 0);

        // Zero history, positive error: every tap moves to +1, no code change.
        for (int k = 0; k < 3; k++) issue(1'b1, 2'b00, 1'b0, 0, 0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 5, 0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 0, 0, 1'b0);

        // Negative history, negative error twice: second sweep crosses THRESH.
        do_reset();
        fill(2'b01);
        issue(1'b0, 2'b00, 1'b1, -1, 0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, -1, 0, 1'b0);

        // Negative history, positive error four times.
        do_reset();
        fill(2'b01);
        for (int k = 0; k < 4; k++) issue(1'b0, 2'b00, 1'b1, 1, 0, 1'b0);

        // Saturation at the positive rail, then walk back down.
        do_reset();
        for (int k = 0; k < ACC_MAX + 2; k++) issue(1'b0, 2'b00, 1'b1, 1, 0, 1'b0);
        for (int k = 0; k < ACC_MAX - 1; k++) issue(1'b0, 2'b00, 1'b1, -1, 0, 1'b0);

        // In-sweep stimulus: held sample, overflow of the hold slot, dropped error.
        do_reset();
        issue(1'b0, 2'b00, 1'b1, 1, 1, 1'b0);
        issue(1'b0, 2'b00, 1'b1, -1, 0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 1, 2, 1'b0);
        do_reset();
        issue(1'b0, 2'b00, 1'b1, 1, 0, 1'b1);
        issue(1'b1, 2'b01, 1'b1, -3, 0, 1'b0);

        // Reset in the middle of a sweep, then a fresh sweep must look like a first one.
        do_reset();
        fill(2'b01);
        valid_err_in = 1'b1;
        err_in       = ERR_W'(1);
        m_sweep(1'b0);
        @(negedge clock);
        valid_err_in = 1'b0;
        repeat (N / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(valid_update_out), 0);
        reset = 1'b0;
        m_reset();
        @(negedge clock);
        check("postreset_valid", int'(valid_update_out), 0);
        fill(2'b01);
        issue(1'b0, 2'b00, 1'b1, 1, 0, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int it = 0; it < 60; it++) begin
            d    = ($urandom_range(0, 1) == 1);
            code = 2'($urandom);
            ev   = ($urandom_range(0, 3) != 0);
            r    = int'($urandom_range(0, 9));
            if (r < 7)       e = int'($urandom_range(0, 6)) - 3;
            else if (r == 7) e = -(1 << (ERR_W - 1));
            else             e = (1 << (ERR_W - 1)) - 1;
            issue(d, code, ev, e, int'($urandom_range(0, 2)), ($urandom_range(0, 5) == 0));
        end

        repeat (4) @(negedge clock);
        check("leftover_updates", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
